// File: rtl/host_fifo_pkg.sv
// Shared host-FIFO definitions: routing constants, payload counter width and
// the command-code to payload-count mapping used by the receive router.
package host_fifo_pkg;

    localparam int          FIFO_PAYLOAD_WIDTH = 8;
    localparam logic [31:0] HOST_SEL_MASK      = 32'h8000_0000;
    localparam int          HOST_CNT_SHIFT     = 16;
    localparam logic [31:0] HOST_CNT_MASK      = 32'h0000_00FF;

    typedef enum logic {
        DEST_F2 = 1'b0,
        DEST_F1 = 1'b1
    } dest_e;

    // Count code to payload word count; kept as a function so the encoding can evolve.
    function automatic logic [FIFO_PAYLOAD_WIDTH-1:0] fifo_payload(
        input logic [FIFO_PAYLOAD_WIDTH-1:0] code
    );
        return code;
    endfunction

endpackage

// File: rtl/fifo_arb_rx.sv
// Host-receive packet router: pops packets (command + N payload words) from an
// FWFT input FIFO and forwards each whole packet to output FIFO 1 or 2.
module fifo_arb_rx
    import host_fifo_pkg::*;
#(
    parameter int          DW        = 32,
    parameter logic [31:0] SEL_MASK  = HOST_SEL_MASK,
    parameter int          CNT_SHIFT = HOST_CNT_SHIFT,
    parameter logic [31:0] CNT_MASK  = HOST_CNT_MASK
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    output logic          rd_en_o,
    input  logic [DW-1:0] rd_data_i,
    input  logic          empty_i,
    output logic          f1_wr_en_o,
    output logic [DW-1:0] f1_wr_data_o,
    input  logic          f1_full_i,
    output logic          f2_wr_en_o,
    output logic [DW-1:0] f2_wr_data_o,
    input  logic          f2_full_i
);

    localparam logic [0:0] ST_CMD     = 1'b0;
    localparam logic [0:0] ST_PAYLOAD = 1'b1;

    logic [0:0]                    state;
    dest_e                         dest;
    logic [FIFO_PAYLOAD_WIDTH-1:0] remaining;

    logic                          sel_f1_n;
    logic [FIFO_PAYLOAD_WIDTH-1:0] cnt_n;
    logic                          route_f1;
    logic                          dst_full;
    logic                          fire;

    // Command decode is evaluated on the head word every cycle; only used in ST_CMD.
    assign sel_f1_n = |(rd_data_i & DW'(SEL_MASK));
    assign cnt_n    = fifo_payload(FIFO_PAYLOAD_WIDTH'((rd_data_i >> CNT_SHIFT) & DW'(CNT_MASK)));

    always_comb begin
        route_f1 = (state == ST_CMD) ? sel_f1_n : (dest == DEST_F1);
        dst_full = route_f1 ? f1_full_i : f2_full_i;
        // Gating with rstn_i forces all strobes low as soon as reset asserts.
        fire     = rstn_i && !empty_i && !dst_full;
    end

    assign rd_en_o      = fire;
    assign f1_wr_en_o   = fire && route_f1;
    assign f2_wr_en_o   = fire && !route_f1;
    assign f1_wr_data_o = rd_data_i;
    assign f2_wr_data_o = rd_data_i;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state     <= ST_CMD;
            remaining <= '0;
            dest      <= DEST_F2;
        end else if (fire) begin
            if (state == ST_CMD) begin
                dest      <= sel_f1_n ? DEST_F1 : DEST_F2;
                remaining <= cnt_n;
                state     <= (cnt_n != '0) ? ST_PAYLOAD : ST_CMD;
            end else begin
                // Saturate at zero; the state change below leaves PAYLOAD on the last word.
                if (remaining != '0) begin
                    remaining <= remaining - FIFO_PAYLOAD_WIDTH'(1);
                end
                if (remaining <= FIFO_PAYLOAD_WIDTH'(1)) begin
                    state <= ST_CMD;
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_arb_rx.sv
// Bench for fifo_arb_rx: directed packet cases plus a randomized stream checked
// against per-destination word queues built when the packets are generated.
module tb_fifo_arb_rx;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        rd_en_o;
    logic [31:0] rd_data_i;
    logic        empty_i;
    logic        f1_wr_en_o;
    logic [31:0] f1_wr_data_o;
    logic        f1_full_i;
    logic        f2_wr_en_o;
    logic [31:0] f2_wr_data_o;
    logic        f2_full_i;

    fifo_arb_rx dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .rd_en_o      (rd_en_o),
        .rd_data_i    (rd_data_i),
        .empty_i      (empty_i),
        .f1_wr_en_o   (f1_wr_en_o),
        .f1_wr_data_o (f1_wr_data_o),
        .f1_full_i    (f1_full_i),
        .f2_wr_en_o   (f2_wr_en_o),
        .f2_wr_data_o (f2_wr_data_o),
        .f2_full_i    (f2_full_i)
    );

    always #5 clk_i = ~clk_i;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] inq[$];
    logic [31:0] exp1[$];
    logic [31:0] exp2[$];
    logic [31:0] got1[$];
    logic [31:0] got2[$];
    bit          last_fire;
    int          cyc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic push_pkt(input logic [31:0] cmd, input int n, input bit rand_payload);
        logic [31:0] w;
        inq.push_back(cmd);
        if ((cmd & 32'h8000_0000) != 0) exp1.push_back(cmd); else exp2.push_back(cmd);
        for (int i = 0; i < n; i++) begin
            w = rand_payload ? $urandom : (32'h1000_0000 + (cmd >> 16) * 32'h100 + i);
            inq.push_back(w);
            if ((cmd & 32'h8000_0000) != 0) exp1.push_back(w); else exp2.push_back(w);
        end
    endtask

    // One clock: drive at negedge, sample 1ns later, well away from the rising edge.
    task automatic step(input bit allow, input bit full1, input bit full2);
        @(negedge clk_i);
        empty_i   = !(allow && inq.size() != 0);
        rd_data_i = 32'hDEAD_BEEF;
        if (inq.size() != 0) rd_data_i = inq[0];
        f1_full_i = full1;
        f2_full_i = full2;
        #1;
        last_fire = rd_en_o;
        chk("pop_matches_push", {31'd0, rd_en_o}, {31'd0, f1_wr_en_o | f2_wr_en_o});
        chk("pop_when_empty", {31'd0, rd_en_o & empty_i}, 32'd0);
        chk("push_f1_full", {31'd0, f1_wr_en_o & f1_full_i}, 32'd0);
        chk("push_f2_full", {31'd0, f2_wr_en_o & f2_full_i}, 32'd0);
        if (f1_wr_en_o) got1.push_back(f1_wr_data_o);
        if (f2_wr_en_o) got2.push_back(f2_wr_data_o);
        if (rd_en_o && inq.size() != 0) void'(inq.pop_front());
        cyc++;
    endtask

    task automatic drain(input string tag, input int budget, input bit full1, input bit full2);
        int n;
        n = 0;
        while (inq.size() != 0 && n < budget) begin
            step(1'b1, full1, full2);
            n++;
        end
        chk({tag, "_left_in_input"}, inq.size(), 0);
    endtask

    task automatic compare_clear(input string tag);
        chk({tag, "_f1_count"}, got1.size(), exp1.size());
        chk({tag, "_f2_count"}, got2.size(), exp2.size());
        for (int i = 0; i < exp1.size() && i < got1.size(); i++) chk({tag, "_f1_word"}, got1[i], exp1[i]);
        for (int i = 0; i < exp2.size() && i < got2.size(); i++) chk({tag, "_f2_word"}, got2[i], exp2[i]);
        got1.delete(); got2.delete(); exp1.delete(); exp2.delete(); inq.delete();
    endtask

    initial begin
        int c0;
        int words;
        rstn_i    = 1'b0;
        empty_i   = 1'b0;
        rd_data_i = 32'h8000_0000;
        f1_full_i = 1'b0;
        f2_full_i = 1'b0;
        cyc       = 0;
        #2;
        chk("reset_rd_en", {31'd0, rd_en_o}, 32'd0);
        chk("reset_f1_en", {31'd0, f1_wr_en_o}, 32'd0);
        chk("reset_f2_en", {31'd0, f2_wr_en_o}, 32'd0);
        @(negedge clk_i);
        empty_i = 1'b1;
        @(negedge clk_i);
        rstn_i = 1'b1;

        // Single packets, each must take exactly one cycle per word.
        push_pkt(32'h8002_0000, 2, 1'b0);
        c0 = cyc; drain("pkt_f1", 20, 1'b0, 1'b0);
        chk("pkt_f1_cycles", cyc - c0, 3);
        compare_clear("pkt_f1");
        push_pkt(32'h0001_0000, 1, 1'b0);
        c0 = cyc; drain("pkt_f2", 20, 1'b0, 1'b0);
        chk("pkt_f2_cycles", cyc - c0, 2);
        compare_clear("pkt_f2");

        // Zero-count commands back to back.
        push_pkt(32'h8000_0000, 0, 1'b0);
        push_pkt(32'h0000_0000, 0, 1'b0);
        c0 = cyc; drain("zero", 20, 1'b0, 1'b0);
        chk("zero_cycles", cyc - c0, 2);
        compare_clear("zero");

        // Destination backpressure mid-packet, and a full F2 never blocking an F1 packet.
        push_pkt(32'h8003_0000, 3, 1'b0);
        step(1'b1, 1'b0, 1'b1); chk("bp_cmd_fire", {31'd0, last_fire}, 32'd1);
        step(1'b1, 1'b0, 1'b0); chk("bp_p0_fire", {31'd0, last_fire}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0); chk("bp_stall", {31'd0, last_fire}, 32'd0);
        end
        step(1'b1, 1'b0, 1'b1); chk("bp_f2full_fire", {31'd0, last_fire}, 32'd1);
        step(1'b1, 1'b0, 1'b0); chk("bp_last_fire", {31'd0, last_fire}, 32'd1);
        compare_clear("bp");

        // Reset while a 5-word packet is half delivered.
        push_pkt(32'h8005_0000, 2, 1'b0);
        drain("rst_pre", 10, 1'b0, 1'b0);
        @(negedge clk_i);
        empty_i   = 1'b0;
        rd_data_i = 32'h1234_5678;
        rstn_i    = 1'b0;
        #1;
        chk("rst_mid_rd_en", {31'd0, rd_en_o}, 32'd0);
        chk("rst_mid_f1_en", {31'd0, f1_wr_en_o}, 32'd0);
        chk("rst_mid_f2_en", {31'd0, f2_wr_en_o}, 32'd0);
        @(negedge clk_i);
        empty_i = 1'b1;
        rstn_i  = 1'b1;
        push_pkt(32'h0001_0000, 1, 1'b0);
        drain("rst_post", 10, 1'b0, 1'b0);
        compare_clear("rst");

        // Maximum count: 256-word packet, then a command proving return to CMD.
        push_pkt(32'h80FF_0000, 255, 1'b1);
        push_pkt(32'h0000_0000, 0, 1'b0);
        c0 = cyc; drain("max", 400, 1'b0, 1'b0);
        chk("max_cycles", cyc - c0, 257);
        compare_clear("max");

        // Random stream with random input and output rates.
        words = 0;
        while (words < 10000) begin
            logic [31:0] cmd;
            int          n;
            n   = $urandom_range(0, 15);
            cmd = ($urandom & 32'hFF00_FFFF) | (32'(n) << 16);
            push_pkt(cmd, n, 1'b1);
            words += n + 1;
        end
        c0 = 0;
        while (inq.size() != 0 && c0 < 60000) begin
            step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3);
            c0++;
        end
        chk("rand_left_in_input", inq.size(), 0);
        compare_clear("rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
